uart_rx_fifo: RTL

- Downstream stage of the sampling UART receiver: captures each received byte strobe into a synchronous FIFO.
- Exposes the buffered bytes to the CPU through a Wishbone classic slave (8-bit data, 4 registers).
- Raises a level interrupt while data is pending, so software can drain bursts without losing bytes between reads.

---
 rtl/uart_rx_fifo.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers receiver byte strobes in a FIFO and exposes them to a CPU over a Wishbone classic slave.
// Latency: a pushed byte is visible in COUNT/STATUS/irq after one edge; each Wishbone access acks on the next cycle.
// Backpressure: none toward the receiver; a byte arriving while full is dropped and flags sticky overflow.
// Optional build macro UART_RX_FIFO_THRESH_IRQ_EN adds a THRESH register at addr 3 and a threshold/overflow irq.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [1:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       irq
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_COUNT  = 2'd2;
  localparam logic [1:0] ADR_THRESH = 2'd3;

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          overflow;
  logic          overflow_next;
  logic          full;
  logic          empty;
  logic          req;
  logic          rd_req;
  logic          wr_req;
  logic          pop;
  logic          push;
  logic          ovf_set;
  logic          ovf_clr;
  logic [7:0]    rdata;
  logic          irq_next;

  // Only some write-data bits are meaningful; fold the rest into a sink.
  logic unused_wb_dat;
  assign unused_wb_dat = ^wb_dat_i;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // The ack register masks a second request while an ack is outstanding,
  // which is what spaces back-to-back accesses to every other cycle.
  assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign rd_req = req & ~wb_we_i;
  assign wr_req = req & wb_we_i;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
  assign pop     = rd_req & (wb_adr_i == ADR_DATA) & ~empty;
  assign push    = rx_valid & (~full | pop);
  assign ovf_set = rx_valid & full & ~pop;
  assign ovf_clr = wr_req & (wb_adr_i == ADR_STATUS) & wb_dat_i[2];

  // Set beats clear so an overflow in the clearing cycle is never lost.
  assign overflow_next = ovf_set | (overflow & ~ovf_clr);

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  logic [AW:0] thresh;
  logic [AW:0] thresh_next;
  logic [AW:0] thresh_eff;

  assign thresh_next = (wr_req && wb_adr_i == ADR_THRESH) ? wb_dat_i[AW:0] : thresh;
  // A threshold of zero would hold irq high on an empty FIFO; treat it as one.
  assign thresh_eff  = (thresh_next == '0) ? (AW+1)'(1) : thresh_next;
  assign irq_next    = (count_next >= thresh_eff) | overflow_next;

  // Threshold register, reset to one so the default behaves like "data pending".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) thresh <= (AW+1)'(1);
    else        thresh <= thresh_next;
  end
`else
  assign irq_next = (count_next != '0);
`endif

  // Occupancy update: simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Read-data mux, sampled from pre-edge state so STATUS/COUNT show the value before this access.
  always_comb begin
    rdata = 8'h00;
    if (rd_req) begin
      case (wb_adr_i)
        ADR_DATA:   rdata = empty ? 8'h00 : mem[rd_ptr];
        ADR_STATUS: rdata = {5'b0, overflow, full, ~empty};
        ADR_COUNT:  rdata = 8'(count);
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        ADR_THRESH: rdata = 8'(thresh);
`else
        ADR_THRESH: rdata = 8'h00;
`endif
        default:    rdata = 8'h00;
      endcase
    end
  end

  // Storage array; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  // Pointers, occupancy, sticky overflow and the registered interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      overflow <= overflow_next;
      irq      <= irq_next;
    end
  end

  // Wishbone response: one-cycle ack with read data registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
    end else begin
      wb_ack_o <= req;
      if (req) wb_dat_o <= rdata;
    end
  end

endmodule
